// File: rtl/icache_sa.sv
// icache_sa: blocking set-associative instruction cache with a single
// controller, multi-beat line refill, per-set round-robin replacement and a
// whole-cache invalidate. At most one miss is outstanding.
module icache_sa #(
  parameter int ADDR_WIDTH      = 16,
  parameter int WORD_WIDTH      = 20,
  parameter int NUM_SETS        = 16,
  parameter int NUM_WAYS        = 4,
  parameter int WORDS_PER_BLOCK = 16,
  parameter int MEM_BEAT_WORDS  = 4
) (
  input  logic                                 clk,
  input  logic                                 rst,
  input  logic [ADDR_WIDTH-1:0]                i_addr,
  input  logic                                 i_valid,
  output logic                                 o_ready,
  input  logic                                 i_flush,
  output logic [WORD_WIDTH-1:0]                o_data,
  output logic                                 o_valid,
  input  logic                                 i_ready,
  output logic [ADDR_WIDTH-1:0]                o_mem_addr,
  output logic                                 o_mem_req_valid,
  input  logic                                 i_mem_req_ready,
  input  logic [MEM_BEAT_WORDS*WORD_WIDTH-1:0] i_mem_data,
  input  logic                                 i_mem_data_valid
);
  localparam int OFF_W     = $clog2(WORDS_PER_BLOCK);
  localparam int SET_W     = $clog2(NUM_SETS);
  localparam int TAG_W     = ADDR_WIDTH - SET_W - OFF_W;
  localparam int NUM_BEATS = WORDS_PER_BLOCK / MEM_BEAT_WORDS;
  localparam int WAY_W     = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
  localparam int BEAT_W    = (NUM_BEATS > 1) ? $clog2(NUM_BEATS) : 1;

  localparam logic [2:0] S_IDLE     = 3'd0;
  localparam logic [2:0] S_MISS_REQ = 3'd1;
  localparam logic [2:0] S_REFILL   = 3'd2;
  localparam logic [2:0] S_RESPOND  = 3'd3;
  localparam logic [2:0] S_FLUSH    = 3'd4;

  logic [2:0]                           state;
  logic [NUM_SETS-1:0][NUM_WAYS-1:0]    valid_q;
  logic [TAG_W-1:0]                     tag_q  [NUM_SETS][NUM_WAYS];
  logic [WORD_WIDTH-1:0]                data_q [NUM_SETS][NUM_WAYS][WORDS_PER_BLOCK];
  logic [WAY_W-1:0]                     rr_q   [NUM_SETS];
  logic [ADDR_WIDTH-1:0]                req_addr;
  logic [WAY_W-1:0]                     victim;
  logic                                 victim_rr;
  logic [BEAT_W-1:0]                    beat_q;
  logic                                 flush_pending;
  logic [SET_W-1:0]                     fset;

  // Field split of the incoming fetch and of the latched miss address.
  logic [TAG_W-1:0] in_tag, req_tag;
  logic [SET_W-1:0] in_set, req_set;
  logic [OFF_W-1:0] in_off, req_off;
  assign in_tag  = i_addr[ADDR_WIDTH-1 -: TAG_W];
  assign in_set  = i_addr[OFF_W +: SET_W];
  assign in_off  = i_addr[OFF_W-1:0];
  assign req_tag = req_addr[ADDR_WIDTH-1 -: TAG_W];
  assign req_set = req_addr[OFF_W +: SET_W];
  assign req_off = req_addr[OFF_W-1:0];

  logic             hit, inv_found, accept, refill_beat, refill_last;
  logic [WAY_W-1:0] hit_way, inv_way, rr_next;
  logic [OFF_W-1:0] beat_base;

  assign o_ready     = !rst && (state == S_IDLE) && !i_flush && (!o_valid || i_ready);
  assign accept      = i_valid && o_ready;
  assign refill_beat = (state == S_REFILL) && i_mem_data_valid;
  assign refill_last = refill_beat && (beat_q == BEAT_W'(NUM_BEATS - 1));
  assign beat_base   = OFF_W'(int'(beat_q) * MEM_BEAT_WORDS);
  assign rr_next     = (NUM_WAYS == 1) ? '0 : rr_q[req_set] + WAY_W'(1);

  // Tag lookup across all ways of the addressed set, plus lowest invalid way.
  always_comb begin
    hit       = 1'b0;
    hit_way   = '0;
    inv_found = 1'b0;
    inv_way   = '0;
    for (int w = 0; w < NUM_WAYS; w++) begin
      if (valid_q[in_set][WAY_W'(w)] && tag_q[in_set][WAY_W'(w)] == in_tag) begin
        hit     = 1'b1;
        hit_way = WAY_W'(w);
      end
      if (!valid_q[in_set][WAY_W'(w)] && !inv_found) begin
        inv_found = 1'b1;
        inv_way   = WAY_W'(w);
      end
    end
  end

  // Line storage: beats land in the victim way; tag written with the last beat.
  always_ff @(posedge clk) begin
    if (!rst && refill_beat) begin
      for (int j = 0; j < MEM_BEAT_WORDS; j++)
        data_q[req_set][victim][beat_base + OFF_W'(j)] <= i_mem_data[j*WORD_WIDTH +: WORD_WIDTH];
      if (refill_last) tag_q[req_set][victim] <= req_tag;
    end
  end

  // Controller: lookup/respond, miss request, refill, deferred and direct flush.
  always_ff @(posedge clk) begin
    if (rst) begin
      state           <= S_IDLE;
      valid_q         <= '0;
      for (int s = 0; s < NUM_SETS; s++) rr_q[SET_W'(s)] <= '0;
      o_valid         <= 1'b0;
      o_data          <= '0;
      o_mem_req_valid <= 1'b0;
      o_mem_addr      <= '0;
      flush_pending   <= 1'b0;
      req_addr        <= '0;
      victim          <= '0;
      victim_rr       <= 1'b0;
      beat_q          <= '0;
      fset            <= '0;
    end else begin
      if (o_valid && i_ready) o_valid <= 1'b0;
      case (state)
        S_IDLE: begin
          if (i_flush) begin
            state <= S_FLUSH;
            fset  <= '0;
          end else if (accept) begin
            if (hit) begin
              o_data  <= data_q[in_set][hit_way][in_off];
              o_valid <= 1'b1;
            end else begin
              // Victim is frozen here so the round-robin pointer cannot move mid-refill.
              req_addr        <= i_addr;
              o_mem_addr      <= {in_tag, in_set, {OFF_W{1'b0}}};
              o_mem_req_valid <= 1'b1;
              victim          <= inv_found ? inv_way : rr_q[in_set];
              victim_rr       <= !inv_found;
              state           <= S_MISS_REQ;
            end
          end
        end
        S_MISS_REQ: begin
          if (i_flush) flush_pending <= 1'b1;
          if (i_mem_req_ready) begin
            o_mem_req_valid <= 1'b0;
            beat_q          <= '0;
            state           <= S_REFILL;
          end
        end
        S_REFILL: begin
          if (i_flush) flush_pending <= 1'b1;
          if (i_mem_data_valid) begin
            beat_q <= beat_q + BEAT_W'(1);
            if (refill_last) begin
              valid_q[req_set][victim] <= 1'b1;
              if (victim_rr) rr_q[req_set] <= rr_next;
              state <= S_RESPOND;
            end
          end
        end
        S_RESPOND: begin
          if (i_flush) flush_pending <= 1'b1;
          if (!o_valid || i_ready) begin
            o_data  <= data_q[req_set][victim][req_off];
            o_valid <= 1'b1;
            fset    <= '0;
            state   <= (flush_pending || i_flush) ? S_FLUSH : S_IDLE;
          end
        end
        S_FLUSH: begin
          flush_pending       <= 1'b0;
          valid_q[fset]       <= '0;
          rr_q[fset]          <= '0;
          fset                <= fset + SET_W'(1);
          if (fset == SET_W'(NUM_SETS - 1)) state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_icache_sa.sv
// Directed bench for icache_sa: reset, cold miss, replacement, backpressure,
// flush from idle, flush during refill and reset during refill.
module tb_icache_sa;
  localparam int AW = 16, WW = 20, NB = 4, BW = 4;

  logic clk = 1'b0, rst = 1'b1;
  logic [AW-1:0] i_addr = '0;
  logic i_valid = 1'b0, i_flush = 1'b0, i_ready = 1'b1;
  logic i_mem_req_ready = 1'b0, i_mem_data_valid = 1'b0;
  logic [BW*WW-1:0] i_mem_data = '0;
  logic o_ready, o_valid, o_mem_req_valid;
  logic [WW-1:0] o_data;
  logic [AW-1:0] o_mem_addr;
  int vectors = 0, errors = 0, cyc = 0;

  icache_sa dut (
    .clk(clk), .rst(rst), .i_addr(i_addr), .i_valid(i_valid), .o_ready(o_ready),
    .i_flush(i_flush), .o_data(o_data), .o_valid(o_valid), .i_ready(i_ready),
    .o_mem_addr(o_mem_addr), .o_mem_req_valid(o_mem_req_valid),
    .i_mem_req_ready(i_mem_req_ready), .i_mem_data(i_mem_data),
    .i_mem_data_valid(i_mem_data_valid)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  // Backing memory contents: each word tagged with its own address.
  function automatic logic [WW-1:0] mem_word(input logic [AW-1:0] a);
    return {4'hC, a};
  endfunction

  function automatic logic [BW*WW-1:0] beat_data(input logic [AW-1:0] base, input int k);
    logic [BW*WW-1:0] r;
    for (int j = 0; j < BW; j++) r[j*WW +: WW] = mem_word(base + AW'(k*BW + j));
    return r;
  endfunction

  function automatic logic [AW-1:0] rp_addr(input int t);
    return AW'((t << 8) | 'h35);
  endfunction

  task automatic do_reset();
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0; i_ready = 1'b1;
    i_mem_req_ready = 1'b0; i_mem_data_valid = 1'b0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;
  endtask

  // Present a fetch until accepted; returns one step after the accept edge.
  task automatic start_fetch(input logic [AW-1:0] a, output logic hit, output bit to, output int acc);
    int n = 0;
    to = 1'b0;
    i_addr = a; i_valid = 1'b1; #1;
    while (!o_ready && n < 100) begin @(posedge clk); #1; n++; end
    if (!o_ready) begin to = 1'b1; i_valid = 1'b0; hit = 1'b0; acc = cyc; return; end
    @(posedge clk); #1;
    acc = cyc; i_valid = 1'b0;
    hit = o_valid;
  endtask

  // Grant the refill request and stream NB beats on consecutive cycles.
  task automatic serve_refill(input int flush_beat, output logic [AW-1:0] maddr, output bit to);
    int n = 0;
    to = 1'b0;
    while (!o_mem_req_valid && n < 20) begin @(posedge clk); #1; n++; end
    if (!o_mem_req_valid) begin to = 1'b1; maddr = '0; return; end
    maddr = o_mem_addr;
    i_mem_req_ready = 1'b1;
    @(posedge clk); #1;
    i_mem_req_ready = 1'b0;
    for (int k = 0; k < NB; k++) begin
      i_mem_data = beat_data(maddr, k); i_mem_data_valid = 1'b1;
      i_flush = (k == flush_beat);
      @(posedge clk); #1;
    end
    i_mem_data_valid = 1'b0; i_flush = 1'b0;
  endtask

  task automatic wait_resp(output logic [WW-1:0] d, output int at, output bit to);
    int n = 0;
    while (!o_valid && n < 50) begin @(posedge clk); #1; n++; end
    to = !o_valid; d = o_data; at = cyc;
  endtask

  task automatic full_fetch(input logic [AW-1:0] a, output logic hit, output logic [WW-1:0] d,
                            output logic [AW-1:0] maddr, output bit to);
    bit t1, t2, t3; int acc, at;
    t2 = 1'b0; maddr = '0;
    start_fetch(a, hit, t1, acc);
    if (!t1 && !hit) serve_refill(-1, maddr, t2);
    wait_resp(d, at, t3);
    to = t1 | t2 | t3;
  endtask

  task automatic test_reset();
    rst = 1'b1; i_valid = 1'b0; i_flush = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    vectors++; if (o_valid !== 1'b0) begin errors++; $display("FAIL rst_o_valid: got %b expected 0", o_valid); end
    vectors++; if (o_data !== '0) begin errors++; $display("FAIL rst_o_data: got %h expected 0", o_data); end
    vectors++; if (o_mem_req_valid !== 1'b0) begin errors++; $display("FAIL rst_mem_req_valid: got %b expected 0", o_mem_req_valid); end
    vectors++; if (o_mem_addr !== '0) begin errors++; $display("FAIL rst_mem_addr: got %h expected 0", o_mem_addr); end
    i_valid = 1'b1; #1;
    vectors++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rst_o_ready: got %b expected 0", o_ready); end
    i_valid = 1'b0; rst = 1'b0; #1;
    vectors++; if (o_ready !== 1'b1) begin errors++; $display("FAIL post_rst_o_ready: got %b expected 1", o_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_cold_miss();
    logic hit; bit t1, t2, t3; int acc, at; logic [AW-1:0] ma; logic [WW-1:0] d;
    start_fetch(16'h1234, hit, t1, acc);
    vectors++; if (hit !== 1'b0) begin errors++; $display("FAIL cold_miss_flag: got %b expected 0", hit); end
    vectors++; if (o_mem_req_valid !== 1'b1) begin errors++; $display("FAIL cold_req_valid: got %b expected 1", o_mem_req_valid); end
    vectors++; if (o_mem_addr !== 16'h1230) begin errors++; $display("FAIL cold_mem_addr: got %h expected 1230", o_mem_addr); end
    vectors++; if (o_ready !== 1'b0) begin errors++; $display("FAIL cold_busy_ready: got %b expected 0", o_ready); end
    serve_refill(-1, ma, t2);
    wait_resp(d, at, t3);
    vectors++; if ((t1 | t2 | t3) !== 1'b0) begin errors++; $display("FAIL cold_timeout: got 1 expected 0"); end
    vectors++; if (at - acc !== 6) begin errors++; $display("FAIL cold_latency: got %0d expected 6", at - acc); end
    vectors++; if (d !== mem_word(16'h1234)) begin errors++; $display("FAIL cold_data: got %h expected %h", d, mem_word(16'h1234)); end
    start_fetch(16'h1235, hit, t1, acc);
    vectors++; if (hit !== 1'b1) begin errors++; $display("FAIL warm_hit_flag: got %b expected 1", hit); end
    vectors++; if (o_data !== mem_word(16'h1235)) begin errors++; $display("FAIL warm_hit_data: got %h expected %h", o_data, mem_word(16'h1235)); end
    @(posedge clk); #1;
  endtask

  task automatic test_replacement();
    int tags[7] = '{2, 4, 5, 6, 2, 3, 4};
    bit exp_hit[7] = '{0, 1, 1, 1, 1, 0, 0};
    logic hit; bit to; logic [AW-1:0] ma; logic [WW-1:0] d;
    do_reset();
    for (int t = 1; t <= 6; t++) begin
      full_fetch(rp_addr(t), hit, d, ma, to);
      vectors++; if (hit !== 1'b0 || to) begin errors++; $display("FAIL repl_fill_miss t=%0d: got hit=%b to=%b expected miss", t, hit, to); end
      vectors++; if (ma !== AW'(t << 8 | 'h30)) begin errors++; $display("FAIL repl_fill_addr t=%0d: got %h expected %h", t, ma, AW'(t << 8 | 'h30)); end
    end
    for (int i = 0; i < 7; i++) begin
      full_fetch(rp_addr(tags[i]), hit, d, ma, to);
      vectors++; if (hit !== exp_hit[i] || to) begin errors++; $display("FAIL repl_hit step=%0d tag=%0d: got %b expected %b", i, tags[i], hit, exp_hit[i]); end
      vectors++; if (d !== mem_word(rp_addr(tags[i]))) begin errors++; $display("FAIL repl_data step=%0d: got %h expected %h", i, d, mem_word(rp_addr(tags[i]))); end
    end
    @(posedge clk); #1;
  endtask

  task automatic test_backpressure();
    logic hit; bit to; logic [AW-1:0] ma; logic [WW-1:0] d, held;
    logic [WW-1:0] got[5];
    int idx = 0, rcv = 0; bit acc_n;
    do_reset();
    full_fetch(16'h4560, hit, d, ma, to);
    @(posedge clk); #1;
    held = '0;
    for (int c = 0; c < 40 && rcv < 5; c++) begin
      i_ready = !(c >= 2 && c <= 4);
      i_valid = (idx < 5); i_addr = 16'h4560 + AW'(idx);
      #1;
      if (!i_ready) begin
        vectors++; if (o_ready !== 1'b0) begin errors++; $display("FAIL bp_ready_stall c=%0d: got %b expected 0", c, o_ready); end
        vectors++; if (o_valid !== 1'b1) begin errors++; $display("FAIL bp_valid_stall c=%0d: got %b expected 1", c, o_valid); end
        if (c == 2) held = o_data;
        else begin
          vectors++; if (o_data !== held) begin errors++; $display("FAIL bp_data_stable c=%0d: got %h expected %h", c, o_data, held); end
        end
      end
      if (o_valid && i_ready && rcv < 5) begin got[rcv] = o_data; rcv++; end
      acc_n = i_valid && o_ready;
      @(posedge clk); #1;
      if (acc_n) idx++;
    end
    i_valid = 1'b0; i_ready = 1'b1;
    vectors++; if (rcv !== 5) begin errors++; $display("FAIL bp_count: got %0d expected 5", rcv); end
    for (int k = 0; k < 5; k++) begin
      vectors++; if (got[k] !== mem_word(16'h4560 + AW'(k))) begin errors++; $display("FAIL bp_word k=%0d: got %h expected %h", k, got[k], mem_word(16'h4560 + AW'(k))); end
    end
  endtask

  task automatic test_flush();
    logic [AW-1:0] lines[4] = '{16'h1000, 16'h2010, 16'h3020, 16'h4F30};
    logic hit; bit to; logic [AW-1:0] ma; logic [WW-1:0] d; logic ov; int n = 0;
    do_reset();
    for (int i = 0; i < 4; i++) full_fetch(lines[i], hit, d, ma, to);
    i_flush = 1'b1; i_valid = 1'b1; i_addr = lines[0]; #1;
    ov = 1'bx;
    while (!o_ready && n < 40) begin
      n++; @(posedge clk); #1;
      i_flush = 1'b0;
      if (n == 1) ov = o_valid;
      #1;
    end
    i_valid = 1'b0;
    vectors++; if (ov !== 1'b0) begin errors++; $display("FAIL flush_no_accept: got o_valid=%b expected 0", ov); end
    vectors++; if (n !== 17) begin errors++; $display("FAIL flush_ready_low: got %0d expected 17", n); end
    @(posedge clk); #1;
    for (int i = 0; i < 4; i++) begin
      full_fetch(lines[i], hit, d, ma, to);
      vectors++; if (hit !== 1'b0 || to) begin errors++; $display("FAIL flush_refetch_miss i=%0d: got hit=%b expected 0", i, hit); end
      vectors++; if (d !== mem_word(lines[i])) begin errors++; $display("FAIL flush_refetch_data i=%0d: got %h expected %h", i, d, mem_word(lines[i])); end
    end
  endtask

  task automatic test_flush_refill();
    logic hit; bit t1, t2, t3; int acc, at, n = 0; logic [AW-1:0] ma; logic [WW-1:0] d;
    do_reset();
    start_fetch(16'h567B, hit, t1, acc);
    serve_refill(2, ma, t2);
    wait_resp(d, at, t3);
    vectors++; if ((t1 | t2 | t3) !== 1'b0 || hit !== 1'b0) begin errors++; $display("FAIL fr_miss: got hit=%b to=%b expected miss", hit, t1 | t2 | t3); end
    vectors++; if (d !== mem_word(16'h567B)) begin errors++; $display("FAIL fr_data: got %h expected %h", d, mem_word(16'h567B)); end
    vectors++; if (at - acc !== 6) begin errors++; $display("FAIL fr_latency: got %0d expected 6", at - acc); end
    while (!o_ready && n < 40) begin n++; @(posedge clk); #1; end
    vectors++; if (n !== 16) begin errors++; $display("FAIL fr_flush_cycles: got %0d expected 16", n); end
    full_fetch(16'h567B, hit, d, ma, t1);
    vectors++; if (hit !== 1'b0 || t1) begin errors++; $display("FAIL fr_refetch_miss: got %b expected 0", hit); end
    vectors++; if (d !== mem_word(16'h567B)) begin errors++; $display("FAIL fr_refetch_data: got %h expected %h", d, mem_word(16'h567B)); end
  endtask

  task automatic test_reset_refill();
    logic hit; bit t1; int acc; logic [AW-1:0] ma; logic [WW-1:0] d;
    @(posedge clk); #1;
    start_fetch(16'h89A6, hit, t1, acc);
    vectors++; if (hit !== 1'b0 || o_mem_addr !== 16'h89A0) begin errors++; $display("FAIL rr_first_miss: got hit=%b addr=%h expected 0/89a0", hit, o_mem_addr); end
    i_mem_req_ready = 1'b1; @(posedge clk); #1; i_mem_req_ready = 1'b0;
    for (int k = 0; k < 2; k++) begin
      i_mem_data = beat_data(16'h89A0, k); i_mem_data_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_mem_data_valid = 1'b0; rst = 1'b1; #1;
    vectors++; if (o_ready !== 1'b0) begin errors++; $display("FAIL rr_ready_in_rst: got %b expected 0", o_ready); end
    @(posedge clk); #1;
    rst = 1'b0;
    vectors++; if (o_mem_addr !== '0 || o_mem_req_valid !== 1'b0) begin errors++; $display("FAIL rr_mem_cleared: got addr=%h req=%b expected 0/0", o_mem_addr, o_mem_req_valid); end
    vectors++; if (o_valid !== 1'b0 || o_data !== '0) begin errors++; $display("FAIL rr_out_cleared: got valid=%b data=%h expected 0/0", o_valid, o_data); end
    for (int k = 2; k < 4; k++) begin
      i_mem_data = beat_data(16'h89A0, k); i_mem_data_valid = 1'b1;
      @(posedge clk); #1;
    end
    i_mem_data_valid = 1'b0;
    vectors++; if (o_valid !== 1'b0 || o_ready !== 1'b1) begin errors++; $display("FAIL rr_beats_ignored: got valid=%b ready=%b expected 0/1", o_valid, o_ready); end
    full_fetch(16'h89A6, hit, d, ma, t1);
    vectors++; if (hit !== 1'b0 || t1 || ma !== 16'h89A0) begin errors++; $display("FAIL rr_refetch_miss: got hit=%b addr=%h expected 0/89a0", hit, ma); end
    vectors++; if (d !== mem_word(16'h89A6)) begin errors++; $display("FAIL rr_refetch_data: got %h expected %h", d, mem_word(16'h89A6)); end
  endtask

  initial begin
    test_reset();
    test_cold_miss();
    test_replacement();
    test_backpressure();
    test_flush();
    test_flush_refill();
    test_reset_refill();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
